// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b mod 2^WIDTH, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d_bit;
    logic             br_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // One full-subtractor cell, reused every RUN cycle on the current LSBs.
    assign d_bit   = sh_a[0] ^ sh_b[0] ^ br;
    assign br_next = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);

    // NOTE: every register here, shift registers included, is reset so an
    // aborted operation leaves no residue; all state updates use <= so the
    // reads within this block see the previous-cycle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            res      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            overflow <= 1'b0;
`endif
        end else begin
            // Handshake outputs trail the state by one cycle.
            busy <= (state == RUN);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        res   <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    res  <= {d_bit, res[WIDTH-1:1]};
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    diff     <= res;
                    borrow   <= br;
                    done     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    overflow <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
`endif
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
